// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - tone codes, C-major frequency table and half-period helper
package tone_pkg;

    localparam logic [3:0] TONE_REST = 4'd0;
    localparam logic [3:0] TONE_C3   = 4'd1;
    localparam logic [3:0] TONE_D3   = 4'd2;
    localparam logic [3:0] TONE_E3   = 4'd3;
    localparam logic [3:0] TONE_F3   = 4'd4;
    localparam logic [3:0] TONE_G3   = 4'd5;
    localparam logic [3:0] TONE_A3   = 4'd6;
    localparam logic [3:0] TONE_B3   = 4'd7;
    localparam logic [3:0] TONE_C4   = 4'd8;
    localparam logic [3:0] TONE_D4   = 4'd9;
    localparam logic [3:0] TONE_E4   = 4'd10;
    localparam logic [3:0] TONE_F4   = 4'd11;
    localparam logic [3:0] TONE_G4   = 4'd12;
    localparam logic [3:0] TONE_A4   = 4'd13;
    localparam logic [3:0] TONE_B4   = 4'd14;
    localparam logic [3:0] TONE_C5   = 4'd15;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    // Note frequency in Hz; the rest code has no frequency.
    function automatic int unsigned tone_freq(input logic [3:0] tone);
        case (tone)
            TONE_C3: return 131;
            TONE_D3: return 147;
            TONE_E3: return 165;
            TONE_F3: return 175;
            TONE_G3: return 196;
            TONE_A3: return 220;
            TONE_B3: return 247;
            TONE_C4: return 262;
            TONE_D4: return 294;
            TONE_E4: return 330;
            TONE_F4: return 349;
            TONE_G4: return 392;
            TONE_A4: return 440;
            TONE_B4: return 494;
            TONE_C5: return 523;
            default: return 0;
        endcase
    endfunction

    // Clock cycles per half square-wave period; rest maps to 1 so callers never see zero.
    function automatic int unsigned half_period(input int unsigned clk_freq, input logic [3:0] tone);
        int unsigned f;
        f = tone_freq(tone);
        if (f == 0) begin
            return 1;
        end
        return clk_freq / (2 * f);
    endfunction

endpackage

// File: rtl/tone_channel.sv
// rtl/tone_channel.sv - one tone channel: IDLE/PLAY FSM, period, tick and duration counters
module tone_channel
    import tone_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int TICK_CYC = 50000,
    parameter int DUR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [3:0]       note_tone,
    input  logic [DUR_W-1:0] note_dur,
    input  logic             note_abort,
    output logic             note_done,
    output logic             ch_out
);

    // The lowest note has the longest half period, so it sizes the period counter.
    localparam int HALF_MAX = int'(half_period(CLK_FREQ, TONE_C3));
    localparam int PER_W    = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int TICK_W   = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);

    logic [PER_W-1:0] half_last [16];

    for (genvar g = 0; g < 16; g++) begin : g_half
        assign half_last[g] = PER_W'(half_period(CLK_FREQ, 4'(g)) - 1);
    end

    logic [0:0]       state_q, state_d;
    logic [3:0]       tone_q, tone_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic             tick_end;
    logic             expire;

    assign tick_end = (tick_q == TICK_LAST);
    // Zero-length notes expire on the first PLAY edge; otherwise on the last cycle of the last tick.
    assign expire   = (dur_q == '0) || ((dur_q == DUR_W'(1)) && tick_end);

    // Next-state logic: accept in IDLE, count and toggle in PLAY, abort beats expiry.
    always_comb begin
        state_d = state_q;
        tone_d  = tone_q;
        dur_d   = dur_q;
        per_d   = per_q;
        tick_d  = tick_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (note_valid) begin
                    state_d = ST_PLAY;
                    tone_d  = note_tone;
                    dur_d   = note_dur;
                    per_d   = '0;
                    tick_d  = '0;
                    out_d   = 1'b0;
                end
            end
            default: begin
                if (note_abort || expire) begin
                    state_d = ST_IDLE;
                    done_d  = !note_abort;
                    per_d   = '0;
                    tick_d  = '0;
                    out_d   = 1'b0;
                end else begin
                    if (tick_end) begin
                        tick_d = '0;
                        dur_d  = dur_q - 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                    if (tone_q != TONE_REST) begin
                        if (per_q == half_last[tone_q]) begin
                            per_d = '0;
                            out_d = !out_q;
                        end else begin
                            per_d = per_q + 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // State registers with synchronous reset that drops any note in flight silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tone_q  <= '0;
            dur_q   <= '0;
            per_q   <= '0;
            tick_q  <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tone_q  <= tone_d;
            dur_q   <= dur_d;
            per_q   <= per_d;
            tick_q  <= tick_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign note_ready = (state_q == ST_IDLE) && !rst;
    assign note_done  = done_q;
    assign ch_out     = out_q;

endmodule

// File: rtl/poly_tone_generator.sv
// rtl/poly_tone_generator.sv - NUM_CH tone channels plus registered mix count; TONE_ABORT_EN adds note_abort
module poly_tone_generator
    import tone_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int NUM_CH   = 2,
    parameter int TICK_HZ  = 1000,
    parameter int DUR_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           note_valid,
    output logic [NUM_CH-1:0]           note_ready,
    input  logic [4*NUM_CH-1:0]         note_tone,
    input  logic [DUR_W*NUM_CH-1:0]     note_dur,
    output logic [NUM_CH-1:0]           note_done,
    output logic [NUM_CH-1:0]           ch_out,
    output logic [$clog2(NUM_CH+1)-1:0] mix_out
`ifdef TONE_ABORT_EN
    ,
    input  logic [NUM_CH-1:0]           note_abort
`endif
);

    localparam int TICK_CYC = CLK_FREQ / TICK_HZ;
    localparam int MIX_W    = $clog2(NUM_CH + 1);

    logic [NUM_CH-1:0] abort_w;
    logic [MIX_W-1:0]  mix_q, mix_d;

`ifdef TONE_ABORT_EN
    assign abort_w = note_abort;
`else
    assign abort_w = '0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tone_channel #(
            .CLK_FREQ (CLK_FREQ),
            .TICK_CYC (TICK_CYC),
            .DUR_W    (DUR_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .note_valid (note_valid[i]),
            .note_ready (note_ready[i]),
            .note_tone  (note_tone[4*i +: 4]),
            .note_dur   (note_dur[DUR_W*i +: DUR_W]),
            .note_abort (abort_w[i]),
            .note_done  (note_done[i]),
            .ch_out     (ch_out[i])
        );
    end

    // Count channels currently driving high.
    always_comb begin
        mix_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_d = mix_d + MIX_W'(ch_out[i]);
        end
    end

    // Mix register: one cycle behind the channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_q <= '0;
        end else begin
            mix_q <= mix_d;
        end
    end

    assign mix_out = mix_q;

endmodule

// File: doc/poly_tone_generator.md
POLY_TONE_GENERATOR -- requirements
Module: poly_tone_generator

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter NUM_CH, default 2, number of independent tone channels (1..8).
REQ-003 Parameter TICK_HZ, default 1000, duration time base in Hz; TICK_CYC = CLK_FREQ/TICK_HZ (integer division).
REQ-004 Parameter DUR_W, default 16, width of per-note duration field in ticks.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 note_valid  input  NUM_CH  per-channel note request.
REQ-008 note_ready  output  NUM_CH  per-channel accept-ready.
REQ-009 note_tone  input  4*NUM_CH  per-channel tone code; channel i at bits [4i+3:4i]; 0 = rest, 1..15 = C3..C5 C-major.
REQ-010 note_dur  input  DUR_W*NUM_CH  per-channel duration in ticks; channel i at bits [DUR_W*i+DUR_W-1:DUR_W*i].
REQ-011 note_done  output  NUM_CH  one-cycle pulse when a note's duration expires.
REQ-012 ch_out  output  NUM_CH  per-channel square wave.
REQ-013 mix_out  output  $clog2(NUM_CH+1)  registered count of channels with ch_out high.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE and PLAY.
REQ-015 note_ready[i] SHALL be 1 exactly when channel i is in IDLE.
REQ-016 Acceptance: note_valid[i] && note_ready[i] on a rising edge latches tone and duration, clears the period and tick counters, and sets ch_out[i]=0.
REQ-017 Accept with duration 0: the channel SHALL enter PLAY and return to IDLE on the next edge with a note_done[i] pulse and no toggle.
REQ-018 Accept with duration D>0: the channel SHALL stay in PLAY exactly D*TICK_CYC cycles, then enter IDLE with note_done[i]=1 for one cycle.
REQ-019 HALF(t) = CLK_FREQ/(2*FREQ(t)) (integer division). FREQ table in Hz: C3 131, D3 147, E3 165, F3 175, G3 196, A3 220, B3 247, C4 262, D4 294, E4 330, F4 349, G4 392, A4 440, B4 494, C5 523.
REQ-020 In PLAY with tone!=0, the period counter SHALL increment each cycle; on reaching HALF(t)-1 it SHALL clear and ch_out[i] SHALL toggle. The first toggle occurs HALF(t) cycles after acceptance.
REQ-021 In PLAY with tone==0 (rest), ch_out[i] SHALL hold 0 while the duration still counts.
REQ-022 On entering IDLE, ch_out[i] SHALL be 0 on the same edge.
REQ-023 note_tone and note_dur SHALL be ignored outside acceptance; changes during PLAY have no effect.
REQ-024 Period counter width SHALL be $clog2(HALF(1)); tick counter width $clog2(TICK_CYC). Counters SHALL never wrap past their terminal value.
REQ-025 mix_out SHALL equal the popcount of ch_out from the previous cycle (1-cycle latency).
REQ-026 Simultaneous acceptance on several channels SHALL be independent; no inter-channel priority exists.

Reset
REQ-027 While rst=1: all channels SHALL be in IDLE; ch_out=0, note_done=0, mix_out=0, all counters 0. note_ready reads 0 during reset and 1 from the first cycle after.
REQ-028 Reset asserted mid-note SHALL abort the note with no note_done pulse.

Configuration
REQ-029 Macro TONE_ABORT_EN defined: adds input note_abort (NUM_CH). note_abort[i]=1 in PLAY forces IDLE on that edge, sets ch_out[i]=0, and produces no note_done. If abort and expiry coincide, abort wins. In IDLE, note_abort is ignored.
REQ-030 TONE_ABORT_EN undefined: the note_abort port SHALL be absent; notes end only on expiry or reset.

Structure
REQ-031 Package tone_pkg SHALL hold the tone-code constants, the FREQ table, and a constant function half_period(clk_freq, tone).
REQ-032 A sub-module tone_channel SHALL implement one channel (FSM, period and tick counters, duration counter). The top instantiates NUM_CH copies plus the mix register.

Verification (CLK_FREQ=1000000, TICK_HZ=1000, NUM_CH=2, DUR_W=16)
REQ-033 Ch0 accept A4 (13), dur 3 -> ch_out[0] toggles every 1136 cycles (first toggle 1136 cycles after accept); note_done[0] pulses after 3000 cycles; ch_out[0]=0; ready returns.
REQ-034 Ch1 rest (0), dur 2 -> ch_out[1] stays 0 for 2000 cycles, then note_done[1] pulses.
REQ-035 Ch0 dur 0 with C3 -> note_done[0] on the next edge, no toggle; mix_out stays 0.
REQ-036 Both channels accept C4 (HALF 1908) on the same edge -> identical waveforms; mix_out goes 0 -> 2 -> 0 with 1-cycle lag.
REQ-037 rst pulsed 500 cycles into a C5 note -> all outputs 0 on the next edge, no note_done; a new note is accepted on the cycle after rst drops.
REQ-038 TONE_ABORT_EN build: abort on the same cycle as expiry -> IDLE with no note_done pulse.
